rvfi_mem_tracker: RTL and testbench
===================================

Name: rvfi_mem_tracker

Overview:
- Producer side of the RVFI memory fields for a single-retire core.
- Snoops the core's data-bus request/response stream and queues each memory transaction in program order.
- On instruction retirement, pops the matching transaction and drives registered rvfi_mem_* outputs that downstream memory-consistency checkers consume.
- Sits between the core wrapper and the RVFI checker harness; never influences the bus.

Parameters:
- XLEN, 32, data/address width; must be a multiple of 8.
- DEPTH, 4, queue entries; power of two, at least 2.

Ports:
- clock  input  1  clock
- reset  input  1  reset, synchronous, active-high
- mem_valid  input  1  core request valid
- mem_ready  input  1  memory accepts request; transfer occurs when mem_valid && mem_ready
- mem_addr  input  XLEN  request address
- mem_rmask  input  XLEN/8  byte read mask; nonzero means a response is expected
- mem_wmask  input  XLEN/8  byte write mask
- mem_wdata  input  XLEN  write data
- mem_rvalid  input  1  read response valid; responses arrive in order
- mem_rdata  input  XLEN  read response data
- ret_valid  input  1  instruction retires this cycle
- ret_mem  input  1  retiring instruction performed one memory transaction
- rvfi_valid  output  1  registered retire strobe
- rvfi_mem_addr  output  XLEN  transaction address
- rvfi_mem_rmask  output  XLEN/8  read mask
- rvfi_mem_wmask  output  XLEN/8  write mask
- rvfi_mem_rdata  output  XLEN  read data
- rvfi_mem_wdata  output  XLEN  write data
- err  output  4  sticky flags: [0] overflow, [1] underflow, [2] incomplete, [3] spurious response

Behaviour:
- Reset: all outputs 0; queue empty; all done bits 0; err = 0. Reset mid-operation discards every entry and in-flight response.
- Entry contents: addr, rmask, wmask, wdata, rdata, done.
- Push on transfer: entry captured at tail.
  - done = 1 immediately if rmask == 0.
  - Transfer with both masks zero is still pushed, as a null access.
- Response (mem_rvalid): writes rdata to the oldest entry with done == 0 and sets its done.
  - Only entries present at the start of the cycle are eligible; a same-cycle push is never completed by a same-cycle response.
  - No eligible entry: err[3] set, response dropped.
- Pop: on ret_valid && ret_mem, the head entry is popped. Outputs register next cycle (latency 1).
  - rvfi_valid = 1, fields copied from the entry.
  - Other cycles: rvfi_valid = 0; rvfi_mem_* hold their previous values.
- ret_valid && !ret_mem: rvfi_valid = 1, all rvfi_mem_* = 0, no pop.
- Empty at pop: err[1] set, outputs as for a non-memory retire.
- Head not done at pop, after any forwarding: err[2] set, entry popped anyway, rvfi_mem_rdata = 0.
- Full: a push with no same-cycle pop sets err[0] and drops the request. A push with a same-cycle pop is accepted.
- Pointers are log2(DEPTH)+1 bits: full when the MSBs differ and the low bits are equal; wrap-around is natural.
- err bits clear only on reset.

Optional Feature:
- RVFI_MEM_TRACKER_FWD_EN defined: a response arriving in the same cycle as a pop of a not-done head is forwarded. Output rdata = mem_rdata, no err[2], and the response is consumed by the head.
- Undefined: the head must already be done at pop; such a response sets err[2] and is then applied to the next not-done entry, or sets err[3] if there is none.

Decomposition:
- Package rvfi_mem_tracker_pkg: entry struct typedef (addr, rmask, wmask, wdata, rdata, done), err bit index constants.
- One sub-module, rvfi_mem_tracker_fifo: storage, pointers, full/empty, oldest-not-done priority search. Top level holds the error logic and output registers.

Test Plan:
- Store then retire: push addr 0x100, wmask 0xF, wdata 0xDEADBEEF; ret_mem next cycle -> rvfi_valid one cycle later, addr 0x100, wmask 0xF, rmask 0, wdata 0xDEADBEEF, err 0.
- Load with latency: push addr 0x204, rmask 0x3; rvalid 3 cycles later with rdata 0x0000BEEF; retire after that -> rmask 0x3, rdata 0x0000BEEF.
- Ordering: push load A, store B, load C; responses 0x11 then 0x33; retire 3 times -> rdata 0x11, B has wmask only, C rdata 0x33.
- Full plus overflow: 4 pushes without retire, 5th push -> err = 0x1; 5th push with same-cycle retire instead -> accepted, err 0.
- Errors: ret_mem on empty -> err[1]. rvalid with no pending load -> err[3]. Retire of an undone load with no same-cycle response -> err[2], rdata 0.
- Forwarding: load head, retire and rvalid (0xCAFE) in the same cycle. FWD_EN defined -> rdata 0xCAFE, err 0. FWD_EN undefined -> err[2] and err[3] both set.

Source files
------------

// File: rtl/rvfi_mem_tracker_pkg.sv
// Shared types for the RVFI memory tracker: queue entry layout and error flag indices.
// Entries are sized for the widest supported XLEN; narrower builds zero-extend into them.
package rvfi_mem_tracker_pkg;

    localparam int unsigned XLEN_MAX = 64;

    localparam int unsigned ERR_OVERFLOW   = 0;
    localparam int unsigned ERR_UNDERFLOW  = 1;
    localparam int unsigned ERR_INCOMPLETE = 2;
    localparam int unsigned ERR_SPURIOUS   = 3;

    typedef struct packed {
        logic [XLEN_MAX-1:0]   addr;
        logic [XLEN_MAX/8-1:0] rmask;
        logic [XLEN_MAX/8-1:0] wmask;
        logic [XLEN_MAX-1:0]   wdata;
        logic [XLEN_MAX-1:0]   rdata;
        logic                  done;
    } mem_entry_t;

    // A request with no read bytes never waits for a response.
    function automatic mem_entry_t make_entry(
        input logic [XLEN_MAX-1:0]   addr,
        input logic [XLEN_MAX/8-1:0] rmask,
        input logic [XLEN_MAX/8-1:0] wmask,
        input logic [XLEN_MAX-1:0]   wdata
    );
        mem_entry_t e;
        e.addr  = addr;
        e.rmask = rmask;
        e.wmask = wmask;
        e.wdata = wdata;
        e.rdata = '0;
        e.done  = (rmask == '0);
        return e;
    endfunction

endpackage

// File: rtl/rvfi_mem_tracker_fifo.sv
// Program-order transaction queue with an oldest-not-done search used to steer
// in-order read responses to their entry.
module rvfi_mem_tracker_fifo
    import rvfi_mem_tracker_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  mem_entry_t          push_entry,
    input  logic                pop,
    input  logic                exclude_head,
    input  logic                resp_write,
    input  logic [XLEN_MAX-1:0] resp_data,
    output mem_entry_t          head,
    output logic                empty,
    output logic                full,
    output logic                hit,
    output logic                hit_head
);

    localparam int unsigned AW = $clog2(DEPTH);

    mem_entry_t      mem [DEPTH];
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;
    logic [AW:0]     count;
    logic [AW-1:0]   hit_idx;
    logic [AW-1:0]   idx;

    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    // Only entries already queued at the start of the cycle are candidates.
    always_comb begin
        hit      = 1'b0;
        hit_head = 1'b0;
        hit_idx  = rptr[AW-1:0];
        idx      = rptr[AW-1:0];
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rptr[AW-1:0] + AW'(i);
            if (!hit && ((AW+1)'(i) < count) && !(exclude_head && (i == 0)) && !mem[idx].done) begin
                hit      = 1'b1;
                hit_head = (i == 0);
                hit_idx  = idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (resp_write) begin
                mem[hit_idx].rdata <= resp_data;
                mem[hit_idx].done  <= 1'b1;
            end
            if (push) begin
                mem[wptr[AW-1:0]] <= push_entry;
                wptr              <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvfi_mem_tracker.sv
// RVFI memory-field producer: queues data-bus transactions and reports one per retire.
// Optional macro RVFI_MEM_TRACKER_FWD_EN forwards a response arriving with the pop of an undone head.
module rvfi_mem_tracker
    import rvfi_mem_tracker_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN/8-1:0] mem_rmask,
    input  logic [XLEN/8-1:0] mem_wmask,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              ret_valid,
    input  logic              ret_mem,
    output logic              rvfi_valid,
    output logic [XLEN-1:0]   rvfi_mem_addr,
    output logic [XLEN/8-1:0] rvfi_mem_rmask,
    output logic [XLEN/8-1:0] rvfi_mem_wmask,
    output logic [XLEN-1:0]   rvfi_mem_rdata,
    output logic [XLEN-1:0]   rvfi_mem_wdata,
    output logic [3:0]        err
);

    logic       xfer, pop, push, full, empty, hit, hit_head;
    logic       exclude_head, fwd, resp_write;
    logic [3:0] err_next;
    mem_entry_t head, push_entry;
    logic       head_unused;

    // Bits above XLEN are always zero in stored entries.
    assign head_unused = ^head;

    assign xfer       = mem_valid && mem_ready;
    assign pop        = ret_valid && ret_mem && !empty;
    assign push       = xfer && (!full || pop);
    assign push_entry = make_entry(XLEN_MAX'(mem_addr), (XLEN_MAX/8)'(mem_rmask),
                                   (XLEN_MAX/8)'(mem_wmask), XLEN_MAX'(mem_wdata));

`ifdef RVFI_MEM_TRACKER_FWD_EN
    assign exclude_head = 1'b0;
    assign fwd          = pop && !head.done && mem_rvalid && hit_head;
`else
    // The head leaves this cycle, so a response must go to a younger entry.
    assign exclude_head = pop;
    assign fwd          = 1'b0;
`endif

    assign resp_write = mem_rvalid && hit && !fwd;

    always_comb begin
        err_next                 = '0;
        err_next[ERR_OVERFLOW]   = xfer && full && !pop;
        err_next[ERR_UNDERFLOW]  = ret_valid && ret_mem && empty;
        err_next[ERR_INCOMPLETE] = pop && !head.done && !fwd;
        err_next[ERR_SPURIOUS]   = mem_rvalid && !hit;
    end

    rvfi_mem_tracker_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push         (push),
        .push_entry   (push_entry),
        .pop          (pop),
        .exclude_head (exclude_head),
        .resp_write   (resp_write),
        .resp_data    (XLEN_MAX'(mem_rdata)),
        .head         (head),
        .empty        (empty),
        .full         (full),
        .hit          (hit),
        .hit_head     (hit_head)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rvfi_valid     <= 1'b0;
            rvfi_mem_addr  <= '0;
            rvfi_mem_rmask <= '0;
            rvfi_mem_wmask <= '0;
            rvfi_mem_rdata <= '0;
            rvfi_mem_wdata <= '0;
            err            <= '0;
        end else begin
            err        <= err | err_next;
            rvfi_valid <= ret_valid;
            if (ret_valid) begin
                if (pop) begin
                    rvfi_mem_addr  <= head.addr[XLEN-1:0];
                    rvfi_mem_rmask <= head.rmask[XLEN/8-1:0];
                    rvfi_mem_wmask <= head.wmask[XLEN/8-1:0];
                    rvfi_mem_wdata <= head.wdata[XLEN-1:0];
                    rvfi_mem_rdata <= head.done ? head.rdata[XLEN-1:0] : (fwd ? mem_rdata : '0);
                end else begin
                    rvfi_mem_addr  <= '0;
                    rvfi_mem_rmask <= '0;
                    rvfi_mem_wmask <= '0;
                    rvfi_mem_wdata <= '0;
                    rvfi_mem_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rvfi_mem_tracker.sv
// Directed scoreboard bench for rvfi_mem_tracker (XLEN=32, DEPTH=4).
// Expectations follow RVFI_MEM_TRACKER_FWD_EN when it is defined for the build.
module tb_rvfi_mem_tracker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid = 1'b0, mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata = '0;
    logic [3:0]  mem_rmask = '0, mem_wmask = '0;
    logic        ret_valid = 1'b0, ret_mem = 1'b0;
    logic        rvfi_valid;
    logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask, err;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    rvfi_mem_tracker #(.XLEN(32), .DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ret_valid(ret_valid), .ret_mem(ret_mem),
        .rvfi_valid(rvfi_valid), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_err(input string tag, input logic [3:0] expv);
        chk(tag, 32'(err), 32'(expv));
    endtask

    // One clock; outputs are sampled 1 time unit after the edge, then inputs return to idle.
    task automatic step();
        exp_t e;
        logic pend;
        @(posedge clock);
        #1;
        pend = (q.size() != 0);
        chk("rvfi_valid", 32'(rvfi_valid), 32'(pend));
        if (rvfi_valid && pend) begin
            e = q.pop_front();
            chk("rvfi_mem_addr", rvfi_mem_addr, e.addr);
            chk("rvfi_mem_rmask", 32'(rvfi_mem_rmask), 32'(e.rmask));
            chk("rvfi_mem_wmask", 32'(rvfi_mem_wmask), 32'(e.wmask));
            chk("rvfi_mem_rdata", rvfi_mem_rdata, e.rdata);
            chk("rvfi_mem_wdata", rvfi_mem_wdata, e.wdata);
        end
        mem_valid = 1'b0; mem_ready = 1'b0; mem_addr = '0; mem_rmask = '0;
        mem_wmask = '0; mem_wdata = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        ret_valid = 1'b0; ret_mem = 1'b0; reset = 1'b0;
    endtask

    task automatic do_reset();
        q.delete();
        reset = 1'b1;
        step();
        step();
    endtask

    task automatic req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd);
        mem_valid = 1'b1; mem_ready = 1'b1; mem_addr = a;
        mem_rmask = rm; mem_wmask = wm; mem_wdata = wd;
    endtask

    task automatic resp(input logic [31:0] d);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
    endtask

    task automatic retire(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                          input logic [31:0] rd, input logic [31:0] wd);
        exp_t e;
        e.addr = a; e.rmask = rm; e.wmask = wm; e.rdata = rd; e.wdata = wd;
        q.push_back(e);
        ret_valid = 1'b1;
        ret_mem   = 1'b1;
    endtask

    task automatic retire_nomem();
        exp_t e;
        e.addr = '0; e.rmask = '0; e.wmask = '0; e.rdata = '0; e.wdata = '0;
        q.push_back(e);
        ret_valid = 1'b1;
        ret_mem   = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset_addr", rvfi_mem_addr, 32'h0);
        chk("reset_rdata", rvfi_mem_rdata, 32'h0);
        chk("reset_wdata", rvfi_mem_wdata, 32'h0);
        chk_err("reset_err", 4'h0);

        // store then retire
        req(32'h100, 4'h0, 4'hF, 32'hDEADBEEF); step();
        retire(32'h100, 4'h0, 4'hF, 32'h0, 32'hDEADBEEF); step();
        chk_err("store_err", 4'h0);

        // load with three-cycle response latency
        req(32'h204, 4'h3, 4'h0, 32'h0); step();
        step(); step();
        resp(32'h0000BEEF); step();
        retire(32'h204, 4'h3, 4'h0, 32'h0000BEEF, 32'h0); step();
        chk_err("load_err", 4'h0);

        // program order across mixed loads and stores
        req(32'h300, 4'hF, 4'h0, 32'h0); step();
        req(32'h304, 4'h0, 4'h3, 32'h55); step();
        req(32'h308, 4'hF, 4'h0, 32'h0); step();
        resp(32'h11); step();
        resp(32'h33); step();
        retire(32'h300, 4'hF, 4'h0, 32'h11, 32'h0); step();
        retire(32'h304, 4'h0, 4'h3, 32'h0, 32'h55); step();
        retire(32'h308, 4'hF, 4'h0, 32'h33, 32'h0); step();
        step();
        chk_err("order_err", 4'h0);

        // full queue: fifth push without a pop is dropped
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req(32'h400 + 32'(4 * i), 4'h0, 4'hF, 32'hA0 + 32'(i)); step();
        end
        chk_err("full_no_err", 4'h0);
        req(32'h410, 4'h0, 4'hF, 32'hA4); step();
        chk_err("overflow_err", 4'h1);
        for (int i = 0; i < 4; i++) begin
            retire(32'h400 + 32'(4 * i), 4'h0, 4'hF, 32'h0, 32'hA0 + 32'(i)); step();
        end
        step();

        // full queue: fifth push with a same-cycle pop is accepted
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req(32'h400 + 32'(4 * i), 4'h0, 4'hF, 32'hA0 + 32'(i)); step();
        end
        req(32'h410, 4'h0, 4'hF, 32'hA4);
        retire(32'h400, 4'h0, 4'hF, 32'h0, 32'hA0); step();
        chk_err("full_pop_err", 4'h0);
        for (int i = 1; i < 5; i++) begin
            retire(32'h400 + 32'(4 * i), 4'h0, 4'hF, 32'h0, 32'hA0 + 32'(i)); step();
        end
        step();
        chk_err("full_pop_drain_err", 4'h0);

        // underflow
        do_reset();
        retire(32'h0, 4'h0, 4'h0, 32'h0, 32'h0); step();
        chk_err("underflow_err", 4'h2);

        // non-memory retire zeroes fields and leaves the queue alone
        do_reset();
        req(32'h120, 4'h0, 4'h1, 32'h7); step();
        retire_nomem(); step();
        retire(32'h120, 4'h0, 4'h1, 32'h0, 32'h7); step();
        chk_err("nomem_err", 4'h0);

        // spurious response
        do_reset();
        resp(32'h5); step();
        chk_err("spurious_err", 4'h8);

        // a same-cycle push is not completed by a same-cycle response
        do_reset();
        req(32'h140, 4'hF, 4'h0, 32'h0); resp(32'h99); step();
        chk_err("same_cycle_err", 4'h8);
        resp(32'h44); step();
        retire(32'h140, 4'hF, 4'h0, 32'h44, 32'h0); step();
        chk_err("same_cycle_err2", 4'h8);

        // retire of an undone load
        do_reset();
        req(32'h600, 4'hF, 4'h0, 32'h0); step();
        retire(32'h600, 4'hF, 4'h0, 32'h0, 32'h0); step();
        chk_err("incomplete_err", 4'h4);

        // response in the same cycle as the pop of an undone head
        do_reset();
        req(32'h500, 4'hF, 4'h0, 32'h0); step();
        resp(32'hCAFE);
`ifdef RVFI_MEM_TRACKER_FWD_EN
        retire(32'h500, 4'hF, 4'h0, 32'hCAFE, 32'h0); step();
        chk_err("fwd_err", 4'h0);
`else
        retire(32'h500, 4'hF, 4'h0, 32'h0, 32'h0); step();
        chk_err("fwd_err", 4'hC);
`endif

        // same situation with a younger undone load behind the head
        do_reset();
        req(32'h700, 4'hF, 4'h0, 32'h0); step();
        req(32'h704, 4'hF, 4'h0, 32'h0); step();
        resp(32'h77);
`ifdef RVFI_MEM_TRACKER_FWD_EN
        retire(32'h700, 4'hF, 4'h0, 32'h77, 32'h0); step();
        chk_err("redirect_err1", 4'h0);
        retire(32'h704, 4'hF, 4'h0, 32'h0, 32'h0); step();
`else
        retire(32'h700, 4'hF, 4'h0, 32'h0, 32'h0); step();
        chk_err("redirect_err1", 4'h4);
        retire(32'h704, 4'hF, 4'h0, 32'h77, 32'h0); step();
`endif
        chk_err("redirect_err2", 4'h4);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
